mutative_tree_plru: RTL and testbench
=====================================

# mutative_tree_plru

Parametrised tree pseudo-LRU replacement engine for the mutative cache. It supports any power-of-two way count and a runtime-selectable associativity from direct-mapped up to fully WAYS-way. The block sits beside the tag/data arrays. It takes hit/fill touches from the cache controller and returns a one-hot victim for the addressed set. On an associativity change it sequences a per-set flush of all PLRU state and reports busy while doing so.

## Interface
- WAYS, 8: total physical ways; power of two, ≥2.
- SETS, 16: number of sets; ≥2.
- WAY_IDX_BITS, $clog2(WAYS): way index width (L below).
- SET_IDX_BITS, $clog2(SETS): set index width.
- MODE_BITS, $clog2(WAY_IDX_BITS+1): mode width.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- mode_i  in  MODE_BITS  requested mode k; associativity 2^k; range 0..L.
- mode_we  in  1  request a change to mode_i.
- set_idx  in  SET_IDX_BITS  set being looked up or touched.
- bank_sel  in  WAY_IDX_BITS  low tag bits; selects the way group.
- touch_valid  in  1  hit or fill on touch_way in set_idx.
- touch_way  in  WAY_IDX_BITS  physical way touched; must lie in the current group.
- evict_way  out  WAY_IDX_BITS  physical victim way.
- evict_we  out  WAYS  one-hot of evict_way; all zero while busy.
- mode_o  out  MODE_BITS  current mode.
- busy  out  1  flush in progress.

## Operation
- **State per set:** L bits... precisely WAYS-1 tree bits, heap-numbered nodes 1..WAYS-1. Node n has children 2n and 2n+1. Leaf node WAYS+w is way w. Node bit 0 means the LRU side is left; bit 1 means it is right.
- **Group selection:** in mode k, group g = bank_sel[L-k-1:0] (g = 0 when k = L). The subtree root is r = 2^(L-k) + g. The group covers ways g·2^k .. g·2^k+2^k−1.
- **Victim:** start at node r and descend k levels following the node bits. The resulting leaf is evict_way.
  - Mode 0: evict_way = bank_sel, with no tree access.
- **Touch:** when touch_valid, not busy and no mode change is accepted, walk from r toward leaf WAYS+touch_way. At each node on the path, write the bit that points away from the direction taken. Nodes above r and all other sets are unchanged. Mode 0 touches have no effect.
- **Mode change:** mode_we in IDLE with mode_i ≠ mode_o is accepted.
  - mode_o updates to mode_i.
  - The FSM enters FLUSH with flush_ptr = 0.
- **FLUSH:** each cycle clears set flush_ptr to all-zero and increments flush_ptr. After set SETS−1 is cleared, the FSM returns to IDLE.
- **Ignored requests:** mode_we with mode_i = mode_o is ignored. mode_we while busy is ignored. mode_i > L is ignored.
- **Priority:** an accepted mode_we in the same cycle as touch_valid drops the touch. Touches during FLUSH are dropped.
- **Reset:** all tree bits = 0, mode_o = L, FSM = IDLE, busy = 0, flush_ptr = 0. Resulting outputs are evict_way = 0 and evict_we = 1. rst mid-flush aborts the flush and applies the full reset.

## Timing
- evict_way and evict_we are combinational from set_idx, bank_sel, mode_o and the stored bits. They reflect state before any touch in the same cycle.
- A touch is written at the clock edge; its effect is visible from the next cycle, including for the same set.
- Flush timing:
  - busy rises the cycle after mode_we is accepted.
  - busy stays high for exactly SETS cycles.
  - The first victim lookup under the new mode is valid in the cycle busy is low again.
- flush_ptr wraps to 0 on exit. The set counter is SET_IDX_BITS wide, with no overflow beyond SETS−1.

## Structure
- Package mutative_types holds plru_mode_t (MODE_BITS), the FSM enum plru_state_t {IDLE, FLUSH} and a helper function for subtree root index.
- One combinational sub-module, mutative_plru_walk. Inputs: tree bits, k, g, touch_way. Outputs: victim leaf and next tree bits. It is generated over levels for any WAYS.
- The top level holds the tree array flops, the mode register, the FSM and the flush counter.

## Test plan
All cases use WAYS=8, SETS=16.
1. **Reset:** rst for 1 cycle → busy=0, mode_o=3, evict_way=0, evict_we=8'h01 for any set_idx.
2. **8-way tree update:** mode 3, set 5.
   - Touch way 0 → next-cycle victim 4.
   - Touch 4 → victim 2.
   - Touch 2 → victim 6.
   - Set 6 still reports victim 0.
3. **Mode change to 4-way:** mode_we with mode_i=2.
   - busy high exactly 16 cycles; evict_we=0 throughout.
   - Then, with bank_sel=1: victim 4, evict_we=8'h10.
   - Touch 4 → victim 6.
4. **Direct-mapped:** mode change to 0, bank_sel=5 → evict_way=5, evict_we=8'h20. Touch way 5 leaves every set's bits unchanged.
5. **Same-cycle touch and read:** mode 3. Touch set 3 way 0 while reading set 3 → evict_way=0 that cycle, 4 the next cycle.
6. **Ignored requests and reset mid-flush:**
   - mode_we with mode_i=mode_o → busy stays 0.
   - mode_we during FLUSH → ignored; flush length stays 16.
   - rst at flush cycle 7 → next cycle busy=0, mode_o=3, all sets give victim 0.

Source files
------------

// File: rtl/mutative_tree_plru_pkg.sv
// Shared types for the mutative cache tree pseudo-LRU engine.
// Holds mode/FSM types, default geometry and the subtree root helper.
package mutative_types;

    localparam int PLRU_WAYS      = 8;
    localparam int PLRU_SETS      = 16;
    localparam int PLRU_L         = $clog2(PLRU_WAYS);
    localparam int PLRU_MODE_BITS = $clog2(PLRU_L + 1);

    typedef logic [PLRU_MODE_BITS-1:0] plru_mode_t;

    typedef enum logic {
        IDLE,
        FLUSH
    } plru_state_t;

    // Heap index of the subtree root for mode k and way group bank.
    // Only the low (l-k) bits of bank select the group.
    function automatic int subtree_root(
        input int l,
        input int k,
        input int bank
    );
        int span;
        span = 1 << (l - k);
        return span + (bank & (span - 1));
    endfunction

endpackage

// File: rtl/mutative_tree_plru_if.sv
// Controller <-> PLRU bundle: mode requests, set lookup, touches,
// victim outputs. master = cache controller, slave = PLRU engine.
interface mutative_tree_plru_if
    import mutative_types::*;
#(
    parameter int WAYS = PLRU_WAYS,
    parameter int SETS = PLRU_SETS
);
    localparam int WIB = $clog2(WAYS);
    localparam int SIB = $clog2(SETS);
    localparam int MB  = $clog2(WIB + 1);

    logic [MB-1:0]  mode_i;
    logic           mode_we;
    logic [SIB-1:0] set_idx;
    logic [WIB-1:0] bank_sel;
    logic           touch_valid;
    logic [WIB-1:0] touch_way;
    logic [WIB-1:0] evict_way;
    logic [WAYS-1:0] evict_we;
    logic [MB-1:0]  mode_o;
    logic           busy;

    modport master (
        output mode_i, mode_we, set_idx, bank_sel,
        output touch_valid, touch_way,
        input  evict_way, evict_we, mode_o, busy
    );

    modport slave (
        input  mode_i, mode_we, set_idx, bank_sel,
        input  touch_valid, touch_way,
        output evict_way, evict_we, mode_o, busy
    );

endinterface

// File: rtl/mutative_tree_plru_walk.sv
// Combinational tree walk: victim descent and touch update from root.
// Ports: bits/k/g/touch_way in; victim leaf and updated bits out.
module mutative_plru_walk
    import mutative_types::*;
#(
    parameter  int WAYS = PLRU_WAYS,
    localparam int L    = $clog2(WAYS),
    localparam int MB   = $clog2(L + 1)
) (
    input  logic [WAYS-2:0] bits,
    input  logic [MB-1:0]   k,
    input  logic [L-1:0]    g,
    input  logic [L-1:0]    touch_way,
    output logic [L-1:0]    victim,
    output logic [WAYS-2:0] bits_nxt
);

    logic [L:0]   vn;
    logic [L:0]   tn;
    logic [L:0]   leaf;
    logic [L:0]   step;
    logic [L-1:0] vidx;
    logic [L-1:0] tidx;
    logic         dir;

    // Node n lives at bits[n-1]; leaf WAYS+w is way w, so after k
    // levels the low L bits of the node index are the way number.
    always_comb begin
        vn       = (L+1)'(subtree_root(L, int'(k), int'(g)));
        tn       = vn;
        leaf     = {1'b1, touch_way};
        step     = '0;
        vidx     = '0;
        tidx     = '0;
        dir      = 1'b0;
        bits_nxt = bits;
        for (int i = 0; i < L; i++) begin
            if (i < int'(k)) begin
                vidx = L'(vn - 1'b1);
                vn   = {vn[L-1:0], bits[vidx]};
                tidx = L'(tn - 1'b1);
                step = leaf >> (int'(k) - i - 1);
                dir  = step[0];
                // LRU side is the one not taken.
                bits_nxt[tidx] = ~dir;
                tn   = {tn[L-1:0], dir};
            end
        end
        victim = vn[L-1:0];
    end

endmodule

// File: rtl/mutative_tree_plru.sv
// Tree PLRU engine: per-set tree bits, mode register, flush FSM.
// Ports: clk, rst (sync, active-high), bus (slave side of the bundle).
module mutative_tree_plru
    import mutative_types::*;
#(
    parameter  int WAYS         = PLRU_WAYS,
    parameter  int SETS         = PLRU_SETS,
    localparam int WAY_IDX_BITS = $clog2(WAYS),
    localparam int SET_IDX_BITS = $clog2(SETS),
    localparam int MODE_BITS    = $clog2(WAY_IDX_BITS + 1)
) (
    input logic                clk,
    input logic                rst,
    mutative_tree_plru_if.slave bus
);

    localparam int L = WAY_IDX_BITS;

    logic [WAYS-2:0]         tree_q [SETS];
    logic [MODE_BITS-1:0]    mode_q;
    logic [MODE_BITS-1:0]    mode_d;
    plru_state_t             state_q;
    plru_state_t             state_d;
    logic [SET_IDX_BITS-1:0] ptr_q;
    logic [SET_IDX_BITS-1:0] ptr_d;

    logic            mode_ok;
    logic            clr;
    logic            touch_en;
    logic [L-1:0]    grp;
    logic [L-1:0]    victim;
    logic [WAYS-2:0] rd_bits;
    logic [WAYS-2:0] wr_bits;

    assign rd_bits = tree_q[bus.set_idx];

    assign mode_ok = bus.mode_we
                  && (state_q == IDLE)
                  && (bus.mode_i != mode_q)
                  && (int'(bus.mode_i) <= L);

    always_comb begin
        grp = bus.bank_sel
            & L'((1 << (L - int'(mode_q))) - 1);
    end

    mutative_plru_walk #(
        .WAYS (WAYS)
    ) u_walk (
        .bits      (rd_bits),
        .k         (mode_q),
        .g         (grp),
        .touch_way (bus.touch_way),
        .victim    (victim),
        .bits_nxt  (wr_bits)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        mode_d   = mode_q;
        clr      = 1'b0;
        touch_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mode_ok) begin
                    mode_d  = bus.mode_i;
                    state_d = FLUSH;
                    ptr_d   = '0;
                end else begin
                    // Mode 0 has no tree, so touches are no-ops.
                    touch_en = bus.touch_valid
                            && (mode_q != '0);
                end
            end
            FLUSH: begin
                clr = 1'b1;
                if (int'(ptr_q) == SETS - 1) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            mode_q  <= MODE_BITS'(L);
            for (int s = 0; s < SETS; s++) begin
                tree_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mode_q  <= mode_d;
            if (clr) begin
                tree_q[ptr_q] <= '0;
            end else if (touch_en) begin
                tree_q[bus.set_idx] <= wr_bits;
            end
        end
    end

    assign bus.busy      = (state_q == FLUSH);
    assign bus.mode_o    = mode_q;
    assign bus.evict_way = victim;
    assign bus.evict_we  = bus.busy
                         ? '0
                         : (WAYS'(1) << victim);

endmodule

// File: tb/tb_mutative_tree_plru.sv
// Directed bench for mutative_tree_plru (WAYS=8, SETS=16).
// Scenario tasks with inline checks; one summary line at the end.
module tb_mutative_tree_plru;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    mutative_tree_plru_if #(.WAYS(8), .SETS(16)) bus ();

    mutative_tree_plru #(
        .WAYS (8),
        .SETS (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic touch(input int s, input int w);
        bus.set_idx     = 4'(s);
        bus.touch_way   = 3'(w);
        bus.touch_valid = 1'b1;
        tick();
        bus.touch_valid = 1'b0;
        #1;
    endtask

    // Request a mode change and count busy cycles (bounded).
    task automatic do_flush(
        input  int m,
        output int len,
        output int we_bad
    );
        bus.mode_i  = 2'(m);
        bus.mode_we = 1'b1;
        tick();
        bus.mode_we = 1'b0;
        len    = 0;
        we_bad = 0;
        while (bus.busy && len < 64) begin
            len++;
            if (bus.evict_we !== 8'h00) we_bad++;
            tick();
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        n_checks++;
        if (bus.mode_o !== 2'd3) begin
            n_fail++;
            $display("FAIL reset_mode got %0d want 3", bus.mode_o);
        end
        for (int s = 0; s < 16; s++) begin
            bus.set_idx = 4'(s);
            #1;
            n_checks++;
            if (bus.evict_way !== 3'd0 || bus.evict_we !== 8'h01) begin
                n_fail++;
                $display("FAIL reset_victim set %0d got %0d/%h want 0/01",
                         s, bus.evict_way, bus.evict_we);
            end
        end
    endtask

    task automatic test_tree_update();
        logic [2:0] exp [3];
        logic [2:0] ways [3];
        exp[0] = 3'd4; exp[1] = 3'd2; exp[2] = 3'd6;
        ways[0] = 3'd0; ways[1] = 3'd4; ways[2] = 3'd2;
        bus.bank_sel = 3'd0;
        for (int i = 0; i < 3; i++) begin
            touch(5, int'(ways[i]));
            n_checks++;
            if (bus.evict_way !== exp[i]) begin
                n_fail++;
                $display("FAIL tree8_touch%0d got %0d want %0d",
                         i, bus.evict_way, exp[i]);
            end
        end
        bus.set_idx = 4'd6;
        #1;
        n_checks++;
        if (bus.evict_way !== 3'd0) begin
            n_fail++;
            $display("FAIL tree8_other_set got %0d want 0",
                     bus.evict_way);
        end
    endtask

    task automatic test_mode_change();
        int len;
        int we_bad;
        do_flush(2, len, we_bad);
        n_checks++;
        if (len != 16) begin
            n_fail++;
            $display("FAIL flush_len got %0d want 16", len);
        end
        n_checks++;
        if (we_bad != 0) begin
            n_fail++;
            $display("FAIL flush_we got %0d nonzero want 0", we_bad);
        end
        n_checks++;
        if (bus.mode_o !== 2'd2) begin
            n_fail++;
            $display("FAIL mode2_o got %0d want 2", bus.mode_o);
        end
        bus.set_idx  = 4'd0;
        bus.bank_sel = 3'd1;
        #1;
        n_checks++;
        if (bus.evict_way !== 3'd4 || bus.evict_we !== 8'h10) begin
            n_fail++;
            $display("FAIL mode2_victim got %0d/%h want 4/10",
                     bus.evict_way, bus.evict_we);
        end
        touch(0, 4);
        n_checks++;
        if (bus.evict_way !== 3'd6) begin
            n_fail++;
            $display("FAIL mode2_touch got %0d want 6", bus.evict_way);
        end
    endtask

    task automatic test_direct_mapped();
        int len;
        int we_bad;
        int dirty;
        do_flush(0, len, we_bad);
        n_checks++;
        if (len != 16 || bus.mode_o !== 2'd0) begin
            n_fail++;
            $display("FAIL dm_flush got len %0d mode %0d want 16/0",
                     len, bus.mode_o);
        end
        bus.set_idx  = 4'd2;
        bus.bank_sel = 3'd5;
        #1;
        n_checks++;
        if (bus.evict_way !== 3'd5 || bus.evict_we !== 8'h20) begin
            n_fail++;
            $display("FAIL dm_victim got %0d/%h want 5/20",
                     bus.evict_way, bus.evict_we);
        end
        touch(2, 5);
        dirty = 0;
        for (int s = 0; s < 16; s++) begin
            if (dut.tree_q[s] !== 7'h00) dirty++;
        end
        n_checks++;
        if (dirty != 0 || bus.evict_way !== 3'd5) begin
            n_fail++;
            $display("FAIL dm_touch got %0d dirty sets way %0d want 0/5",
                     dirty, bus.evict_way);
        end
    endtask

    task automatic test_same_cycle();
        int len;
        int we_bad;
        do_flush(3, len, we_bad);
        bus.bank_sel    = 3'd0;
        bus.set_idx     = 4'd3;
        bus.touch_way   = 3'd0;
        bus.touch_valid = 1'b1;
        #1;
        n_checks++;
        if (bus.evict_way !== 3'd0) begin
            n_fail++;
            $display("FAIL same_cycle_before got %0d want 0",
                     bus.evict_way);
        end
        tick();
        bus.touch_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.evict_way !== 3'd4) begin
            n_fail++;
            $display("FAIL same_cycle_after got %0d want 4",
                     bus.evict_way);
        end
    endtask

    task automatic test_ignored_and_reset();
        int len;
        int bad;
        bus.mode_i  = 2'd3;
        bus.mode_we = 1'b1;
        tick();
        bus.mode_we = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL same_mode_busy got %b want 0", bus.busy);
        end
        // Start 3 -> 1, then try 2 mid-flush.
        bus.mode_i  = 2'd1;
        bus.mode_we = 1'b1;
        tick();
        bus.mode_we = 1'b0;
        len = 0;
        while (bus.busy && len < 64) begin
            len++;
            bus.mode_we = (len == 3);
            bus.mode_i  = 2'd2;
            tick();
        end
        bus.mode_we = 1'b0;
        n_checks++;
        if (len != 16 || bus.mode_o !== 2'd1) begin
            n_fail++;
            $display("FAIL busy_we got len %0d mode %0d want 16/1",
                     len, bus.mode_o);
        end
        // Dirty a late set so an incomplete clear is visible.
        bus.bank_sel = 3'd0;
        touch(12, 0);
        bus.mode_i  = 2'd3;
        bus.mode_we = 1'b1;
        tick();
        bus.mode_we = 1'b0;
        len = 0;
        while (bus.busy && len < 7) begin
            len++;
            if (len < 7) tick();
        end
        n_checks++;
        if (len != 7) begin
            n_fail++;
            $display("FAIL rst_flush_reach got %0d want 7", len);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.mode_o !== 2'd3) begin
            n_fail++;
            $display("FAIL rst_mid got busy %b mode %0d want 0/3",
                     bus.busy, bus.mode_o);
        end
        bad = 0;
        for (int s = 0; s < 16; s++) begin
            bus.set_idx = 4'(s);
            #1;
            if (bus.evict_way !== 3'd0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_mid_sets got %0d bad sets want 0", bad);
        end
    endtask

    initial begin
        bus.mode_i      = 2'd0;
        bus.mode_we     = 1'b0;
        bus.set_idx     = 4'd0;
        bus.bank_sel    = 3'd0;
        bus.touch_valid = 1'b0;
        bus.touch_way   = 3'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        test_reset();
        test_tree_update();
        test_mode_change();
        test_direct_mapped();
        test_same_cycle();
        test_ignored_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
